// File: rtl/enc_pkg.sv
// Shared definitions for the Hamming encoder output stage: mode codes,
// per-mode codeword geometry and the skid-buffer state encoding.
package enc_pkg;

    localparam logic [1:0] MOD_1 = 2'd0;
    localparam logic [1:0] MOD_2 = 2'd1;
    localparam logic [1:0] MOD_3 = 2'd2;

    localparam int unsigned NUM_MODES = 3;

    // Codeword width and parity-bit count, indexed by mode code
    localparam int unsigned MODE_CW [NUM_MODES] = '{8, 16, 32};
    localparam int unsigned MODE_P  [NUM_MODES] = '{4, 5, 6};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic int unsigned mode_cw(input logic [1:0] mode);
        int unsigned cw;
        case (mode)
            MOD_1:   cw = MODE_CW[0];
            MOD_2:   cw = MODE_CW[1];
            MOD_3:   cw = MODE_CW[2];
            default: cw = 0;
        endcase
        return cw;
    endfunction

    function automatic int unsigned mode_p(input logic [1:0] mode);
        int unsigned p;
        case (mode)
            MOD_1:   p = MODE_P[0];
            MOD_2:   p = MODE_P[1];
            MOD_3:   p = MODE_P[2];
            default: p = 0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/enc_parity_stage_if.sv
// Port bundle of the encoder output stage: upstream word input, downstream
// word output and the delivered-word counter.
interface enc_parity_stage_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 32,
    parameter int unsigned CNTW = 16
) ();

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   data_in;
    logic [AW-1:0]   work_mod;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   data_out;
    logic            out_err;
    logic [CNTW-1:0] word_cnt;

    modport master (
        output in_valid, data_in, work_mod, out_ready,
        input  in_ready, out_valid, data_out, out_err, word_cnt
    );

    modport slave (
        input  in_valid, data_in, work_mod, out_ready,
        output in_ready, out_valid, data_out, out_err, word_cnt
    );

endinterface

// File: rtl/enc_skid_buf.sv
// Two-entry valid/ready buffer. in_ready is decoded from state only, so
// there is no combinational path from out_ready back upstream.
module enc_skid_buf
    import enc_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             deliver;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = out_q;
    assign accept      = in_valid_i && in_ready_o;
    assign deliver     = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // The skid register only fills when the output register is stalled
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    out_d   = in_data_i;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    out_d = in_data_i;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/enc_parity_stage.sv
// Final Hamming encoder stage: inserts the overall parity bit for the word's
// mode, masks unused upper bits, buffers the result and counts legal words.
module enc_parity_stage
    import enc_pkg::*;
#(
    parameter int unsigned MAX_CODEWORD_WIDTH = 32,
    parameter int unsigned AMBA_WORD          = 32,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    enc_parity_stage_if.slave bus_if
);

    localparam int unsigned DW = MAX_CODEWORD_WIDTH;

    logic [1:0]           mode_sel;
    logic                 upper_zero;
    logic                 mode_legal;
    int unsigned          cw;
    int unsigned          pw;
    logic                 parity;
    logic [DW-1:0]        res_data;
    logic                 res_err;
    logic [DW:0]          in_payload;
    logic [DW:0]          out_payload;
    logic                 deliver;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign mode_sel   = bus_if.work_mod[1:0];
    assign upper_zero = (bus_if.work_mod[AMBA_WORD-1:2] == '0);

    // Parity covers [cw-1:0] except its own slot at pw-1, whose input is ignored
    always_comb begin
        cw         = mode_cw(mode_sel);
        pw         = mode_p(mode_sel);
        mode_legal = upper_zero && (cw != 0) && (cw <= DW);
        parity     = 1'b0;
        res_data   = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if ((i < cw) && (i != pw - 1)) begin
                parity = parity ^ bus_if.data_in[i];
            end
        end
        for (int unsigned i = 0; i < DW; i++) begin
            if (i < cw) begin
                res_data[i] = (i == pw - 1) ? parity : bus_if.data_in[i];
            end
        end
        res_err = !mode_legal;
        if (!mode_legal) begin
            res_data = '0;
        end
    end

    assign in_payload = {res_err, res_data};

    enc_skid_buf #(
        .WIDTH (DW + 1)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (bus_if.in_valid),
        .in_ready_o  (bus_if.in_ready),
        .in_data_i   (in_payload),
        .out_valid_o (bus_if.out_valid),
        .out_ready_i (bus_if.out_ready),
        .out_data_o  (out_payload)
    );

    assign bus_if.data_out = out_payload[DW-1:0];
    assign bus_if.out_err  = out_payload[DW];

    assign deliver = bus_if.out_valid && bus_if.out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Only error-free words count; the counter wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (deliver && !bus_if.out_err) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus_if.word_cnt = cnt_q;

endmodule

// File: tb/tb_enc_parity_stage.sv
// Scoreboard bench for enc_parity_stage: a full-width instance and a
// 16-bit / 4-bit-counter instance driven from one sequenced initial block.
module tb_enc_parity_stage;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [32:0] expQ[$];
    logic [32:0] gotQ[$];
    logic [16:0] exp16Q[$];
    logic [16:0] got16Q[$];
    logic [15:0] cntExp = '0;
    logic [3:0]  cnt16Exp = '0;

    logic [31:0] vecData [5] = '{32'hFFFF_FF76, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 32'h0000_ABCD};
    logic [31:0] vecMode [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'h0000_0100};
    logic [32:0] vecExp  [5] = '{{1'b0, 32'h0000_007E}, {1'b0, 32'h0000_FFFF}, {1'b0, 32'h0000_0021},
                                 {1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0000}};

    enc_parity_stage_if #(.DW(32), .AW(32), .CNTW(16)) bus ();
    enc_parity_stage_if #(.DW(16), .AW(32), .CNTW(4))  bus16 ();

    enc_parity_stage #(
        .MAX_CODEWORD_WIDTH (32),
        .AMBA_WORD          (32),
        .CNT_WIDTH          (16)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus)
    );

    enc_parity_stage #(
        .MAX_CODEWORD_WIDTH (16),
        .AMBA_WORD          (32),
        .CNT_WIDTH          (4)
    ) dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: mask to codeword width, clear the parity slot, then set it to the XOR
    function automatic logic [32:0] model(input logic [31:0] d, input logic [31:0] m, input int maxw);
        int          cw;
        int          pb;
        logic [31:0] r;
        if (m > 32'd2) return {1'b1, 32'h0};
        case (m[1:0])
            2'd0:    begin cw = 8;  pb = 3; end
            2'd1:    begin cw = 16; pb = 4; end
            default: begin cw = 32; pb = 5; end
        endcase
        if (cw > maxw) return {1'b1, 32'h0};
        r = (cw == 32) ? d : (d & ((32'h1 << cw) - 32'h1));
        r[pb] = 1'b0;
        r[pb] = ^r;
        return {1'b0, r};
    endfunction

    task automatic cycleMain(input logic v, input logic [31:0] d, input logic [31:0] m,
                             input logic rdy, output logic acc);
        bus.in_valid  = v;
        bus.data_in   = d;
        bus.work_mod  = m;
        bus.out_ready = rdy;
        #1;
        acc = v && bus.in_ready;
        if (acc) expQ.push_back(model(d, m, 32));
        if (bus.out_valid && rdy) gotQ.push_back({bus.out_err, bus.data_out});
        @(negedge clk);
    endtask

    task automatic cycle16(input logic v, input logic [15:0] d, input logic [31:0] m,
                           input logic rdy, output logic acc);
        logic [32:0] e;
        bus16.in_valid  = v;
        bus16.data_in   = d;
        bus16.work_mod  = m;
        bus16.out_ready = rdy;
        #1;
        acc = v && bus16.in_ready;
        if (acc) begin
            e = model({16'h0, d}, m, 16);
            exp16Q.push_back({e[32], e[15:0]});
        end
        if (bus16.out_valid && rdy) got16Q.push_back({bus16.out_err, bus16.data_out});
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;   bus.data_in = '0;   bus.work_mod = '0;   bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.data_in = '0; bus16.work_mod = '0; bus16.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0", bus.data_out); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", bus.out_err); end
        checks++; if (bus.word_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_word_cnt: got %0d expected 0", bus.word_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes();
        logic        acc;
        logic        idleAcc;
        logic [32:0] got;
        logic [32:0] exp;
        for (int i = 0; i < 5; i++) begin
            cycleMain(1'b1, vecData[i], vecMode[i], 1'b1, acc);
            cycleMain(1'b0, 32'h0, 32'h0, 1'b1, idleAcc);
            if (vecExp[i][32] == 1'b0) cntExp = cntExp + 16'd1;
            checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL modes_accept[%0d]: got %b expected 1", i, acc); end
            checks++;
            if (gotQ.size() != 1 || expQ.size() != 1) begin
                errors++; $display("[TB] FAIL modes_latency[%0d]: got %0d words expected 1", i, gotQ.size());
                gotQ.delete(); expQ.delete();
            end else begin
                got = gotQ.pop_front();
                exp = expQ.pop_front();
                checks++; if (got !== vecExp[i]) begin errors++; $display("[TB] FAIL modes_word[%0d]: got err=%b data=%h expected err=%b data=%h", i, got[32], got[31:0], vecExp[i][32], vecExp[i][31:0]); end
                checks++; if (exp !== vecExp[i]) begin errors++; $display("[TB] FAIL modes_model[%0d]: got %h expected %h", i, exp, vecExp[i]); end
            end
            checks++; if (bus.word_cnt !== cntExp) begin errors++; $display("[TB] FAIL modes_word_cnt[%0d]: got %0d expected %0d", i, bus.word_cnt, cntExp); end
        end
    endtask

    task automatic test_backpressure();
        logic        acc;
        logic [32:0] expA;
        logic [32:0] got;
        logic [32:0] exp;
        logic [31:0] wordA = 32'h0000_1111;
        logic [31:0] wordB = 32'h8000_0003;
        logic [31:0] wordC = 32'h7FFF_FFDF;
        expA = model(wordA, 32'd2, 32);
        cycleMain(1'b1, wordA, 32'd2, 1'b0, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_A: got %b expected 1", acc); end
        cycleMain(1'b1, wordB, 32'd2, 1'b0, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_B: got %b expected 1", acc); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_full: got %b expected 0", bus.in_ready); end
        for (int k = 0; k < 2; k++) begin
            cycleMain(1'b1, wordC, 32'd2, 1'b0, acc);
            checks++; if (acc !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_C[%0d]: got %b expected 0", k, acc); end
            checks++; if ({bus.out_err, bus.data_out} !== expA || bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable[%0d]: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.data_out, expA[31:0]); end
        end
        cycleMain(1'b1, wordC, 32'd2, 1'b1, acc);
        checks++; if (acc !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_accept_full: got %b expected 0", acc); end
        cycleMain(1'b1, wordC, 32'd2, 1'b1, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept_C: got %b expected 1", acc); end
        cycleMain(1'b0, 32'h0, 32'h0, 1'b1, acc);
        checks++; if (gotQ.size() != 3 || expQ.size() != 3) begin errors++; $display("[TB] FAIL bp_count: got %0d words expected 3", gotQ.size()); end
        for (int k = 0; k < 3; k++) begin
            if (gotQ.size() > 0 && expQ.size() > 0) begin
                got = gotQ.pop_front();
                exp = expQ.pop_front();
                checks++; if (got !== exp) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", k, got, exp); end
                if (exp[32] == 1'b0) cntExp = cntExp + 16'd1;
            end
        end
        gotQ.delete(); expQ.delete();
        checks++; if (bus.word_cnt !== cntExp) begin errors++; $display("[TB] FAIL bp_word_cnt: got %0d expected %0d", bus.word_cnt, cntExp); end
    endtask

    task automatic test_back_to_back();
        logic        acc;
        logic        pend = 1'b0;
        logic [31:0] pd = '0;
        logic [31:0] pm = '0;
        logic        rdy;
        logic [32:0] got;
        logic [32:0] exp;
        int          cyc;
        for (int k = 0; k < 8; k++) begin
            cycleMain(1'b1, $urandom(), 32'($urandom_range(0, 2)), 1'b1, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_throughput[%0d]: got %b expected 1", k, acc); end
        end
        for (int n = 0; n < 60; n++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                pd   = $urandom();
                pm   = ($urandom_range(0, 7) == 0) ? 32'h0000_0104 : 32'($urandom_range(0, 3));
            end
            rdy = ($urandom_range(0, 2) != 0);
            cycleMain(pend, pd, pm, rdy, acc);
            if (acc) pend = 1'b0;
        end
        cyc = 0;
        while ((bus.out_valid === 1'b1) && cyc < 10) begin
            cycleMain(1'b0, 32'h0, 32'h0, 1'b1, acc);
            cyc++;
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got out_valid=%b expected 0", bus.out_valid); end
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d words expected %0d", gotQ.size(), expQ.size()); end
        while (gotQ.size() > 0 && expQ.size() > 0) begin
            got = gotQ.pop_front();
            exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL b2b_word: got %h expected %h", got, exp); end
            if (exp[32] == 1'b0) cntExp = cntExp + 16'd1;
        end
        gotQ.delete(); expQ.delete();
        checks++; if (bus.word_cnt !== cntExp) begin errors++; $display("[TB] FAIL b2b_word_cnt: got %0d expected %0d", bus.word_cnt, cntExp); end
    endtask

    task automatic test_reset_midstream();
        logic        acc;
        logic [32:0] got;
        cycleMain(1'b1, 32'hCAFE_0001, 32'd1, 1'b0, acc);
        cycleMain(1'b1, 32'hCAFE_0002, 32'd1, 1'b0, acc);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_full: got in_ready=%b expected 0", bus.in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_data_out: got %h expected 0", bus.data_out); end
        checks++; if (bus.word_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_mid_word_cnt: got %0d expected 0", bus.word_cnt); end
        gotQ.delete(); expQ.delete();
        cntExp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycleMain(1'b1, 32'h0000_005D, 32'd0, 1'b1, acc);
        cycleMain(1'b0, 32'h0, 32'h0, 1'b1, acc);
        checks++;
        if (gotQ.size() != 1) begin
            errors++; $display("[TB] FAIL rst_mid_first_word: got %0d words expected 1", gotQ.size());
        end else begin
            got = gotQ.pop_front();
            checks++; if (got !== {1'b0, 32'h0000_0055}) begin errors++; $display("[TB] FAIL rst_mid_word: got %h expected 0_00000055", got); end
        end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_narrow();
        logic        acc;
        logic [16:0] got;
        logic [16:0] exp;
        cycle16(1'b1, 16'hBEEF, 32'd2, 1'b1, acc);
        cycle16(1'b0, 16'h0, 32'd0, 1'b1, acc);
        checks++;
        if (got16Q.size() != 1) begin
            errors++; $display("[TB] FAIL narrow_mode2_count: got %0d words expected 1", got16Q.size());
        end else begin
            got = got16Q.pop_front();
            checks++; if (got !== {1'b1, 16'h0}) begin errors++; $display("[TB] FAIL narrow_mode2_err: got err=%b data=%h expected err=1 data=0000", got[16], got[15:0]); end
        end
        got16Q.delete(); exp16Q.delete();
        checks++; if (bus16.word_cnt !== 4'd0) begin errors++; $display("[TB] FAIL narrow_cnt_after_err: got %0d expected 0", bus16.word_cnt); end
        for (int k = 0; k < 17; k++) begin
            cycle16(1'b1, 16'($urandom()), 32'(k % 2), 1'b1, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL narrow_accept[%0d]: got %b expected 1", k, acc); end
        end
        cycle16(1'b0, 16'h0, 32'd0, 1'b1, acc);
        checks++; if (got16Q.size() != 17 || exp16Q.size() != 17) begin errors++; $display("[TB] FAIL narrow_count: got %0d words expected 17", got16Q.size()); end
        while (got16Q.size() > 0 && exp16Q.size() > 0) begin
            got = got16Q.pop_front();
            exp = exp16Q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL narrow_word: got %h expected %h", got, exp); end
            if (exp[16] == 1'b0) cnt16Exp = cnt16Exp + 4'd1;
        end
        checks++; if (bus16.word_cnt !== 4'd1) begin errors++; $display("[TB] FAIL narrow_wrap: got %0d expected 1", bus16.word_cnt); end
        checks++; if (bus16.word_cnt !== cnt16Exp) begin errors++; $display("[TB] FAIL narrow_cnt_model: got %0d expected %0d", bus16.word_cnt, cnt16Exp); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
